// File: rtl/freq_gen.sv
// Phase-accumulator square-wave generator with a serial shift-subtract tuning-word divider.
// New tuning words are applied on an accumulator wrap so every output phase stays whole.
module freq_gen #(
  parameter int unsigned SYS_CLK_FREQ = 100_000_000,
  parameter int unsigned ACC_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [31:0]      freq_set,
  input  logic             set_valid,
  output logic             set_ready,
  output logic             clk_out,
  output logic [ACC_W-1:0] tw_out,
  output logic             err,
  output logic             running
);

  localparam logic [31:0]     Divisor = 32'(SYS_CLK_FREQ);
  localparam logic [31:0]     MaxFreq = Divisor >> 1;
  localparam int unsigned     CntW    = $clog2(ACC_W + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(ACC_W);

  typedef enum logic [1:0] {StIdle, StCalc, StPend} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [31:0]      rem_q, rem_d;
  logic [32:0]      rem_sh;
  logic [ACC_W-1:0] quo_q, quo_d;
  logic             clamp_q, clamp_d;
  logic             err_q, err_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] tw_q, tw_d;
  logic [ACC_W:0]   sum;
  logic             clk_out_q, clk_out_d;
  logic             running_q, running_d;
  logic             wrap;
  logic             apply;

  assign set_ready = (state_q == StIdle);
  assign clk_out   = clk_out_q;
  assign tw_out    = tw_q;
  assign err       = err_q;
  assign running   = running_q;

  // Request capture and divider. The dividend's upper half (freq_eff) is always below the
  // divisor, so only the lower ACC_W quotient bits can be non-zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    clamp_d = clamp_q;
    err_d   = 1'b0;
    rem_sh  = {rem_q, 1'b0};
    unique case (state_q)
      StIdle: begin
        if (set_valid) begin
          clamp_d = (freq_set > MaxFreq);
          rem_d   = (freq_set > MaxFreq) ? MaxFreq : freq_set;
          quo_d   = '0;
          cnt_d   = '0;
          state_d = StCalc;
        end
      end
      StCalc: begin
        err_d = clamp_q && (cnt_q == '0);
        if (cnt_q == LastCnt) begin
          state_d = StPend;
        end else begin
          if (rem_sh >= {1'b0, Divisor}) begin
            rem_d = 32'(rem_sh - {1'b0, Divisor});
            quo_d = {quo_q[ACC_W-2:0], 1'b1};
          end else begin
            rem_d = rem_sh[31:0];
            quo_d = {quo_q[ACC_W-2:0], 1'b0};
          end
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StPend: begin
        if (apply) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    sum   = {1'b0, acc_q} + {1'b0, tw_q};
    acc_d = acc_q;
    wrap  = 1'b0;
    if (en) begin
      acc_d = sum[ACC_W-1:0];
      wrap  = sum[ACC_W];
    end else if (acc_q[ACC_W-1] && (tw_q != '0)) begin
      // Finish the high phase; the edge that leaves it (always a wrap) parks the accumulator.
      wrap  = sum[ACC_W];
      acc_d = sum[ACC_W-1] ? sum[ACC_W-1:0] : '0;
    end else begin
      acc_d = '0;
    end
    apply     = (state_q == StPend) && ((tw_q == '0) || !running_q || wrap);
    tw_d      = apply ? quo_q : tw_q;
    clk_out_d = acc_d[ACC_W-1];
    running_d = (tw_d != '0) && (en || (acc_d != '0));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      clamp_q   <= 1'b0;
      err_q     <= 1'b0;
      acc_q     <= '0;
      tw_q      <= '0;
      clk_out_q <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      clamp_q   <= clamp_d;
      err_q     <= err_d;
      acc_q     <= acc_d;
      tw_q      <= tw_d;
      clk_out_q <= clk_out_d;
      running_q <= running_d;
    end
  end

endmodule

// File: tb/tb_freq_gen.sv
// Self-checking bench for freq_gen: vector table, directed phase sequences and randomized
// requests compared against an arithmetic tuning-word and output-rate model.
module tb_freq_gen;

  localparam longint unsigned SysClk = 100_000_000;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [31:0] freq_set;
  logic        set_valid;
  logic        set_ready;
  logic        clk_out;
  logic [31:0] tw_out;
  logic        err;
  logic        running;

  int checks;
  int errors;

  freq_gen dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .freq_set  (freq_set),
    .set_valid (set_valid),
    .set_ready (set_ready),
    .clk_out   (clk_out),
    .tw_out    (tw_out),
    .err       (err),
    .running   (running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] freq;
    logic [31:0] tw;
    logic        err;
  } vec_t;

  vec_t vecs[9];
  int   runs[$];
  int   chg_at;
  logic chg_prev;
  logic chg_now;

  function automatic logic [31:0] model_tw(input logic [31:0] f);
    longint unsigned fe;
    fe = (longint'(f) > SysClk / 2) ? SysClk / 2 : longint'(f);
    return 32'((fe << 32) / SysClk);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 64'(set_ready), 64'd1);
    check({tag, "_clk_out"}, 64'(clk_out), 64'd0);
    check({tag, "_tw"}, 64'(tw_out), 64'd0);
    check({tag, "_err"}, 64'(err), 64'd0);
    check({tag, "_running"}, 64'(running), 64'd0);
  endtask

  // immediate=1: expect the word applied at T+34; otherwise return after the T+33 sample.
  task automatic request(input logic [31:0] f, input logic [31:0] exp_tw, input logic exp_err,
                         input bit immediate, input string tag);
    int n;
    n = immediate ? 34 : 33;
    check({tag, "_ready_before"}, 64'(set_ready), 64'd1);
    @(negedge clk);
    freq_set  = f;
    set_valid = 1'b1;
    @(posedge clk);
    #1;
    set_valid = 1'b0;
    check({tag, "_busy_T"}, 64'(set_ready), 64'd0);
    check({tag, "_err_T"}, 64'(err), 64'd0);
    for (int i = 1; i <= n; i++) begin
      @(posedge clk);
      #1;
      if (i == 1) check({tag, "_err_T1"}, 64'(err), 64'(exp_err));
      if (i == 2) check({tag, "_err_T2"}, 64'(err), 64'd0);
      if (i == 33) check({tag, "_busy_T33"}, 64'(set_ready), 64'd0);
      if (i == 34) begin
        check({tag, "_tw"}, 64'(tw_out), 64'(exp_tw));
        check({tag, "_ready_after"}, 64'(set_ready), 64'd1);
      end
    end
  endtask

  // runs[0] is a partial run; chg_at records the sample where tw_out first changed.
  task automatic sample_runs(input int n);
    logic        prev;
    int          run;
    logic [31:0] old_tw;
    runs.delete();
    chg_at = -1;
    prev   = clk_out;
    run    = 0;
    old_tw = tw_out;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (chg_at < 0 && tw_out !== old_tw) begin
        chg_at   = i;
        chg_prev = prev;
        chg_now  = clk_out;
      end
      if (clk_out === prev) run++;
      else begin
        runs.push_back(run);
        run = 1;
      end
      prev = clk_out;
    end
  endtask

  task automatic wait_stopped(input int limit, input string tag);
    for (int i = 0; i < limit && running !== 1'b0; i++) begin
      @(posedge clk);
      #1;
    end
    check(tag, 64'(running), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          min_run;
    int          cnt;
    bit          found;
    logic        prev;
    logic [31:0] f;
    logic [31:0] tw_exp;
    longint      rises;
    longint      rate_exp;

    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    en        = 1'b0;
    set_valid = 1'b0;
    freq_set  = '0;

    vecs[0] = '{32'd25_000_000, 32'h4000_0000, 1'b0};
    vecs[1] = '{32'd60_000_000, 32'h8000_0000, 1'b1};
    vecs[2] = '{32'd12_500_000, 32'h2000_0000, 1'b0};
    vecs[3] = '{32'd0,          32'h0000_0000, 1'b0};
    vecs[4] = '{32'd1,          32'd42,        1'b0};
    vecs[5] = '{32'd50_000_000, 32'h8000_0000, 1'b0};
    vecs[6] = '{32'd50_000_001, 32'h8000_0000, 1'b1};
    vecs[7] = '{32'd1_000_000,  32'd42_949_672, 1'b0};
    vecs[8] = '{32'd7,          32'd300,       1'b0};

    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Table of requests with the output disabled: every word applies at T+34.
    foreach (vecs[i]) request(vecs[i].freq, vecs[i].tw, vecs[i].err, 1'b1, $sformatf("vec%0d", i));

    // 25 MHz, enable rising in the acceptance cycle.
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    check_reset_outputs("reset2");
    @(negedge clk);
    rst_n = 1'b1;
    en    = 1'b1;
    request(32'd25_000_000, 32'h4000_0000, 1'b0, 1'b1, "f25");
    check("f25_running", 64'(running), 64'd1);
    sample_runs(17);
    check("f25_nruns", 64'(runs.size() >= 6), 64'd1);
    cnt = 0;
    for (int i = 1; i < runs.size(); i++) if (runs[i] != 2) cnt++;
    check("f25_phase_len", 64'(cnt), 64'd0);

    // Retune to 12.5 MHz while running; word must change on a wrap.
    request(32'd12_500_000, 32'h2000_0000, 1'b0, 1'b0, "f12");
    sample_runs(60);
    check("f12_changed", 64'(chg_at >= 0), 64'd1);
    check("f12_wrap_prev_hi", 64'(chg_prev), 64'd1);
    check("f12_wrap_now_lo", 64'(chg_now), 64'd0);
    check("f12_tw", 64'(tw_out), 64'h2000_0000);
    min_run = 99;
    for (int i = 1; i < runs.size(); i++) if (runs[i] < min_run) min_run = runs[i];
    check("f12_min_phase_ge2", 64'(min_run >= 2), 64'd1);
    check("f12_nruns", 64'(runs.size() >= 4), 64'd1);
    if (runs.size() >= 4) begin
      check("f12_last_hi_lo_a", 64'(runs[runs.size()-1]), 64'd4);
      check("f12_last_hi_lo_b", 64'(runs[runs.size()-2]), 64'd4);
    end

    // Drop enable during the first high cycle; the high phase must run to 4 cycles.
    found = 1'b0;
    prev  = clk_out;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge clk);
      #1;
      if (!prev && clk_out) found = 1'b1;
      prev = clk_out;
    end
    check("stop_found_rise", 64'(found), 64'd1);
    en = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("stop_hold_hi%0d", i), 64'(clk_out), 64'd1);
    end
    check("stop_running_before", 64'(running), 64'd1);
    @(posedge clk);
    #1;
    check("stop_low", 64'(clk_out), 64'd0);
    check("stop_running_after", 64'(running), 64'd0);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (clk_out !== 1'b0 || running !== 1'b0) cnt++;
    end
    check("stop_stays_idle", 64'(cnt), 64'd0);

    // Reset at T+10 during the divide, then a clean request.
    @(negedge clk);
    en        = 1'b1;
    freq_set  = 32'd25_000_000;
    set_valid = 1'b1;
    @(posedge clk);
    #1;
    set_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midcalc");
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("midcalc_hold");
    @(negedge clk);
    rst_n = 1'b1;
    request(32'd25_000_000, 32'h4000_0000, 1'b0, 1'b1, "after_rst");

    // Zero word parks the output, then the smallest non-zero request.
    request(32'd0, 32'd0, 1'b0, 1'b0, "zero");
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge clk);
      #1;
      if (tw_out === 32'd0) found = 1'b1;
    end
    check("zero_applied", 64'(found), 64'd1);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (clk_out !== 1'b0) cnt++;
    end
    check("zero_stuck_low", 64'(cnt), 64'd0);
    request(32'd1, 32'd42, 1'b0, 1'b1, "one");
    en = 1'b0;
    wait_stopped(300, "one_stopped");

    // Randomized requests against the arithmetic model.
    for (int k = 0; k < 20; k++) begin
      f = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 50_000_000));
      request(f, model_tw(f), (longint'(f) > SysClk / 2), 1'b1, $sformatf("rnd%0d", k));
    end

    // Randomized output rate: rising edges over 1000 cycles vs. floor(1000*tw/2^32).
    for (int k = 0; k < 4; k++) begin
      f      = 32'($urandom_range(1_000_000, 50_000_000));
      tw_exp = model_tw(f);
      request(f, tw_exp, 1'b0, 1'b1, $sformatf("rate%0d", k));
      @(negedge clk);
      en    = 1'b1;
      rises = 0;
      prev  = clk_out;
      for (int i = 0; i < 1000; i++) begin
        @(posedge clk);
        #1;
        if (!prev && clk_out) rises++;
        prev = clk_out;
      end
      rate_exp = (1000 * longint'(tw_exp)) >>> 32;
      checks++;
      if (rises < rate_exp - 1 || rises > rate_exp + 1) begin
        errors++;
        $display("FAIL rate%0d: got %0d rising edges expected %0d +/-1", k, rises, rate_exp);
      end
      en = 1'b0;
      wait_stopped(300, $sformatf("rate%0d_stopped", k));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
